multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Main control FSM for the multicycle MIPS datapath. It decodes the opcode held in the instruction register and steps through the fetch, decode, execute, memory and writeback phases. In each phase it drives the datapath strobes and mux selects: PC source, ALU operand selects, memory and register-file enables. The memory interface can stall the sequence through a ready handshake.

## Interface
Parameters:
- none; encodings are fixed in the shared package.

Ports:
- clk  in  1  system clock; all state changes happen on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  instruction bits [31:26] from the instruction register; valid from DECODE onward.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified externally with ALU zero (beq).
- pc_src  out  2  00 = ALU result (PC+4), 01 = ALUOut (branch target), 10 = jump address {pc[31:28], instr[25:0], 2'b00}, 11 = reserved.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  write register select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  writeback data select: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- alu_op  out  2  00 = add, 01 = subtract, 10 = decode funct, 11 = reserved.
- illegal  out  1  one-cycle pulse when an unsupported opcode is decoded.
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- State sequences: FETCH -> DECODE -> one of:
  - MEM_ADDR -> MEM_READ -> MEM_WB (lw)
  - MEM_ADDR -> MEM_WRITE (sw)
  - R_EXEC -> R_WB (R-type)
  - BRANCH (beq)
  - JUMP (j)
  - ADDI_EXEC -> ADDI_WB (addi)
- Every terminal state returns to FETCH.
- Outputs are a Moore decode of the state. Any output not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write=1 and pc_write=1 only in the cycle where mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; computes the branch target into ALUOut.
- MEM_ADDR and ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00.
- MEM_READ: mem_read=1, i_or_d=1.
- MEM_WRITE: mem_write=1, i_or_d=1.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01.
- JUMP: pc_write=1, pc_src=10.
- Unsupported opcode in DECODE: illegal=1 for that cycle, next state FETCH. No register or memory side effect; PC has already advanced by 4.
- instr_done=1 in these cycles: MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP, the exit cycle of MEM_WRITE, and the illegal-decode cycle.

## Timing
- Reset: while rst=1, state goes to FETCH at the next edge and every output is forced to 0, including FETCH strobes. First fetch request appears in the cycle after rst is sampled low.
- Reset mid-instruction (including during a wait state) abandons the instruction. No write strobe is emitted after rst is sampled high.
- Handshake: FETCH, MEM_READ and MEM_WRITE each hold their request level until mem_ready=1 is seen. The state advances on that edge.
- mem_ready outside these three states is ignored.
- Cycle counts with zero wait states:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Each cycle with mem_ready=0 in a memory state adds one cycle.
- ir_write is asserted in exactly one cycle per instruction, as is pc_write in FETCH.
- opcode is sampled only in DECODE; changes in other states have no effect.

## Structure
- Shared package `mc_pkg` holds:
  - state enum (4-bit)
  - opcode constants
  - pc_src, alu_src_b and alu_op encodings
- `mc_pkg` is shared with the datapath muxes and the ALU control.
- One natural sub-module: `mc_output_decode`, a purely combinational state-to-strobe decode with mem_ready gating. Next-state logic and the state register stay in the top.

## Test plan
- Reset, then lw with mem_ready tied to 1 -> state sequence FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB. reg_write=1 with mem_to_reg=1 in cycle 5, instr_done in cycle 5.
- R-type followed by j -> R_WB has reg_dst=1, reg_write=1. The JUMP cycle has pc_write=1, pc_src=10. Seven cycles total.
- beq -> BRANCH cycle shows pc_write_cond=1, pc_src=01, alu_op=01. No reg_write in any cycle.
- sw with mem_ready low for 3 cycles in MEM_WRITE -> mem_write held 4 cycles; total instruction time 7 cycles; exactly one instr_done.
- Opcode 111111 -> illegal pulses once in DECODE, next state FETCH. No reg_write or mem_write.
- rst asserted in the MEM_READ wait state -> next cycle all outputs 0. After release, a fetch restarts with mem_read=1, i_or_d=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller, datapath muxes and ALU control.
package mc_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StRExec    = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  typedef enum logic [1:0] {
    PcSrcAlu    = 2'b00,
    PcSrcAluOut = 2'b01,
    PcSrcJump   = 2'b10,
    PcSrcRsvd   = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    AluBRegB   = 2'b00,
    AluBFour   = 2'b01,
    AluBImm    = 2'b10,
    AluBImmSh2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10,
    AluOpRsvd  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    pc_src_e    pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    logic       illegal;
    logic       instr_done;
  } ctrl_t;

  function automatic logic op_supported(logic [5:0] op);
    return (op == OpRtype) || (op == OpLw) || (op == OpSw) ||
           (op == OpBeq) || (op == OpJ) || (op == OpAddi);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory strobe bundle; master is the controller.
interface multicycle_controller_if;

  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_src;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       illegal;
  logic       instr_done;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal, instr_done
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal, instr_done
  );

endinterface

// File: rtl/mc_output_decode.sv
// Combinational state-to-strobe decode; mem_ready only qualifies the completing cycle.
module mc_output_decode
  import mc_pkg::*;
(
  input  logic       rst,
  input  state_e     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    // Reset forces every strobe low, including those of the FETCH state.
    if (!rst) begin
      unique case (state)
        StFetch: begin
          ctrl.mem_read  = 1'b1;
          ctrl.i_or_d    = 1'b0;
          ctrl.alu_src_a = 1'b0;
          ctrl.alu_src_b = AluBFour;
          ctrl.alu_op    = AluOpAdd;
          ctrl.pc_src    = PcSrcAlu;
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
        StDecode: begin
          ctrl.alu_src_a = 1'b0;
          ctrl.alu_src_b = AluBImmSh2;
          ctrl.alu_op    = AluOpAdd;
          if (!op_supported(opcode)) begin
            ctrl.illegal    = 1'b1;
            ctrl.instr_done = 1'b1;
          end
        end
        StMemAddr, StAddiExec: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = AluBImm;
          ctrl.alu_op    = AluOpAdd;
        end
        StMemRead: begin
          ctrl.mem_read = 1'b1;
          ctrl.i_or_d   = 1'b1;
        end
        StMemWrite: begin
          ctrl.mem_write  = 1'b1;
          ctrl.i_or_d     = 1'b1;
          ctrl.instr_done = mem_ready;
        end
        StMemWb: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_dst    = 1'b0;
          ctrl.instr_done = 1'b1;
        end
        StRExec: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = AluBRegB;
          ctrl.alu_op    = AluOpFunct;
        end
        StRWb: begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = 1'b1;
          ctrl.mem_to_reg = 1'b0;
          ctrl.instr_done = 1'b1;
        end
        StAddiWb: begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = 1'b0;
          ctrl.mem_to_reg = 1'b0;
          ctrl.instr_done = 1'b1;
        end
        StBranch: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_src_b     = AluBRegB;
          ctrl.alu_op        = AluOpSub;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_src        = PcSrcAluOut;
          ctrl.instr_done    = 1'b1;
        end
        StJump: begin
          ctrl.pc_write   = 1'b1;
          ctrl.pc_src     = PcSrcJump;
          ctrl.instr_done = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath: state register and next-state logic.
module multicycle_controller
  import mc_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master bus
);

  state_e state_q, state_d;
  logic   is_store_q, is_store_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFetch;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
    end
  end

  // opcode is only valid in DECODE, so lw/sw is remembered for the MEM_ADDR branch.
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    unique case (state_q)
      StFetch: begin
        if (bus.mem_ready) state_d = StDecode;
      end
      StDecode: begin
        is_store_d = (bus.opcode == OpSw);
        case (bus.opcode)
          OpLw, OpSw: state_d = StMemAddr;
          OpRtype:    state_d = StRExec;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StAddiExec;
          default:    state_d = StFetch;
        endcase
      end
      StMemAddr:  state_d = is_store_q ? StMemWrite : StMemRead;
      StMemRead: begin
        if (bus.mem_ready) state_d = StMemWb;
      end
      StMemWrite: begin
        if (bus.mem_ready) state_d = StFetch;
      end
      StRExec:    state_d = StRWb;
      StAddiExec: state_d = StAddiWb;
      StMemWb, StRWb, StAddiWb, StBranch, StJump: state_d = StFetch;
      default:    state_d = StFetch;
    endcase
  end

  mc_output_decode u_output_decode (
    .rst       (rst),
    .state     (state_q),
    .opcode    (bus.opcode),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.pc_src        = ctrl.pc_src;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.illegal       = ctrl.illegal;
  assign bus.instr_done    = ctrl.instr_done;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed cycle tables plus a randomized instruction-queue model.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
    logic       instr_done;
  } out_t;

  typedef struct {
    bit         rst;
    logic [5:0] op;
    bit         rdy;
    out_t       exp;
    string      name;
  } vec_t;

  typedef enum int {PhFetch, PhDecode, PhAddr, PhRead, PhLoadWb, PhWrite,
                    PhRExec, PhRWb, PhBranch, PhJump, PhAddiExec, PhAddiWb} phase_e;

  localparam out_t EZero   = '0;
  localparam out_t EFetchW = '{mem_read: 1'b1, alu_src_b: 2'b01, default: '0};
  localparam out_t EFetchR = '{mem_read: 1'b1, alu_src_b: 2'b01, ir_write: 1'b1, pc_write: 1'b1,
                               default: '0};
  localparam out_t EDec    = '{alu_src_b: 2'b11, default: '0};
  localparam out_t EIll    = '{alu_src_b: 2'b11, illegal: 1'b1, instr_done: 1'b1, default: '0};
  localparam out_t EExec   = '{alu_src_a: 1'b1, alu_src_b: 2'b10, default: '0};
  localparam out_t EMrd    = '{mem_read: 1'b1, i_or_d: 1'b1, default: '0};
  localparam out_t EMwrW   = '{mem_write: 1'b1, i_or_d: 1'b1, default: '0};
  localparam out_t EMwrR   = '{mem_write: 1'b1, i_or_d: 1'b1, instr_done: 1'b1, default: '0};
  localparam out_t EMwb    = '{reg_write: 1'b1, mem_to_reg: 1'b1, instr_done: 1'b1, default: '0};
  localparam out_t ERex    = '{alu_src_a: 1'b1, alu_op: 2'b10, default: '0};
  localparam out_t ERwb    = '{reg_write: 1'b1, reg_dst: 1'b1, instr_done: 1'b1, default: '0};
  localparam out_t EAwb    = '{reg_write: 1'b1, instr_done: 1'b1, default: '0};
  localparam out_t EBr     = '{alu_src_a: 1'b1, alu_op: 2'b01, pc_write_cond: 1'b1, pc_src: 2'b01,
                               instr_done: 1'b1, default: '0};
  localparam out_t EJmp    = '{pc_write: 1'b1, pc_src: 2'b10, instr_done: 1'b1, default: '0};

  localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2b, BEQ = 6'h04, J = 6'h02, ADDI = 6'h08;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic out_t sample();
    out_t o;
    o.pc_write      = bus.pc_write;
    o.pc_write_cond = bus.pc_write_cond;
    o.pc_src        = bus.pc_src;
    o.i_or_d        = bus.i_or_d;
    o.mem_read      = bus.mem_read;
    o.mem_write     = bus.mem_write;
    o.ir_write      = bus.ir_write;
    o.reg_dst       = bus.reg_dst;
    o.mem_to_reg    = bus.mem_to_reg;
    o.reg_write     = bus.reg_write;
    o.alu_src_a     = bus.alu_src_a;
    o.alu_src_b     = bus.alu_src_b;
    o.alu_op        = bus.alu_op;
    o.illegal       = bus.illegal;
    o.instr_done    = bus.instr_done;
    return o;
  endfunction

  // One clock cycle: drive inputs after the falling edge, compare mid-low-phase.
  task automatic apply(input bit r, input logic [5:0] op, input bit rdy, input out_t exp,
                       input string name);
    out_t got;
    @(negedge clk);
    rst           = r;
    bus.opcode    = op;
    bus.mem_ready = rdy;
    #1;
    got = sample();
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic bit legal(logic [5:0] op);
    return op inside {R, LW, SW, BEQ, J, ADDI};
  endfunction

  function automatic out_t model_out(phase_e ph, bit rdy, bit ok);
    case (ph)
      PhFetch:               return rdy ? EFetchR : EFetchW;
      PhDecode:              return ok ? EDec : EIll;
      PhAddr, PhAddiExec:    return EExec;
      PhRead:                return EMrd;
      PhWrite:               return rdy ? EMwrR : EMwrW;
      PhLoadWb:              return EMwb;
      PhRExec:               return ERex;
      PhRWb:                 return ERwb;
      PhAddiWb:              return EAwb;
      PhBranch:              return EBr;
      default:               return EJmp;
    endcase
  endfunction

  vec_t tbl[$];

  initial begin
    phase_e     q[$];
    logic [5:0] cur_op;
    bus.opcode    = '0;
    bus.mem_ready = 1'b0;

    // lw, R-type, j, beq, addi back to back, plus a fetch wait; opcode noise outside DECODE.
    tbl.push_back('{1'b1, SW,   1'b1, EZero,   "reset0"});
    tbl.push_back('{1'b1, LW,   1'b0, EZero,   "reset1"});
    tbl.push_back('{1'b0, BEQ,  1'b1, EFetchR, "lw_fetch"});
    tbl.push_back('{1'b0, LW,   1'b1, EDec,    "lw_decode"});
    tbl.push_back('{1'b0, J,    1'b1, EExec,   "lw_addr"});
    tbl.push_back('{1'b0, SW,   1'b1, EMrd,    "lw_read"});
    tbl.push_back('{1'b0, SW,   1'b0, EMwb,    "lw_wb"});
    tbl.push_back('{1'b0, R,    1'b1, EFetchR, "r_fetch"});
    tbl.push_back('{1'b0, R,    1'b0, EDec,    "r_decode"});
    tbl.push_back('{1'b0, BEQ,  1'b0, ERex,    "r_exec"});
    tbl.push_back('{1'b0, J,    1'b1, ERwb,    "r_wb"});
    tbl.push_back('{1'b0, J,    1'b1, EFetchR, "j_fetch"});
    tbl.push_back('{1'b0, J,    1'b0, EDec,    "j_decode"});
    tbl.push_back('{1'b0, R,    1'b1, EJmp,    "j_jump"});
    tbl.push_back('{1'b0, BEQ,  1'b1, EFetchR, "beq_fetch"});
    tbl.push_back('{1'b0, BEQ,  1'b1, EDec,    "beq_decode"});
    tbl.push_back('{1'b0, LW,   1'b1, EBr,     "beq_branch"});
    tbl.push_back('{1'b0, ADDI, 1'b1, EFetchR, "addi_fetch"});
    tbl.push_back('{1'b0, ADDI, 1'b1, EDec,    "addi_decode"});
    tbl.push_back('{1'b0, SW,   1'b1, EExec,   "addi_exec"});
    tbl.push_back('{1'b0, SW,   1'b1, EAwb,    "addi_wb"});
    tbl.push_back('{1'b0, R,    1'b0, EFetchW, "fetch_wait"});
    tbl.push_back('{1'b0, R,    1'b1, EFetchR, "fetch_done"});
    tbl.push_back('{1'b0, R,    1'b1, EDec,    "tail_decode"});
    tbl.push_back('{1'b0, R,    1'b1, ERex,    "tail_exec"});
    tbl.push_back('{1'b0, R,    1'b1, ERwb,    "tail_wb"});
    foreach (tbl[i]) apply(tbl[i].rst, tbl[i].op, tbl[i].rdy, tbl[i].exp, tbl[i].name);

    // sw with three wait cycles in MEM_WRITE: seven cycles, one instr_done.
    apply(1'b0, SW, 1'b1, EFetchR, "sw_fetch");
    apply(1'b0, SW, 1'b0, EDec,    "sw_decode");
    apply(1'b0, LW, 1'b0, EExec,   "sw_addr");
    for (int i = 0; i < 3; i++) apply(1'b0, LW, 1'b0, EMwrW, "sw_write_wait");
    apply(1'b0, LW, 1'b1, EMwrR,   "sw_write_done");

    // Unsupported opcode: single illegal pulse, straight back to FETCH.
    apply(1'b0, 6'h3f, 1'b1, EFetchR, "ill_fetch");
    apply(1'b0, 6'h3f, 1'b1, EIll,    "ill_decode");
    apply(1'b0, 6'h3f, 1'b0, EFetchW, "ill_refetch");
    apply(1'b0, LW,    1'b1, EFetchR, "ill_refetch_done");

    // Reset while lw waits in MEM_READ abandons it; fetch restarts from PC.
    apply(1'b0, LW, 1'b0, EDec,    "rst_lw_decode");
    apply(1'b0, LW, 1'b0, EExec,   "rst_lw_addr");
    apply(1'b0, LW, 1'b0, EMrd,    "rst_lw_wait");
    apply(1'b1, LW, 1'b1, EZero,   "rst_mid0");
    apply(1'b1, LW, 1'b1, EZero,   "rst_mid1");
    apply(1'b0, LW, 1'b0, EFetchW, "rst_refetch");
    apply(1'b0, LW, 1'b1, EFetchR, "rst_refetch_done");

    // Randomized phase: queue of expected phases per instruction.
    apply(1'b1, 6'h00, 1'b0, EZero, "rand_reset");
    for (int c = 0; c < 3000; c++) begin
      phase_e     ph;
      bit         rdy;
      logic [5:0] op_drv;
      if ($urandom_range(0, 199) == 0) begin
        q.delete();
        apply(1'b1, 6'($urandom), 1'($urandom), EZero, "rand_rst");
        continue;
      end
      if (q.size() == 0) begin
        int k;
        k = $urandom_range(0, 6);
        case (k)
          0: cur_op = R;
          1: cur_op = LW;
          2: cur_op = SW;
          3: cur_op = BEQ;
          4: cur_op = J;
          5: cur_op = ADDI;
          default: begin
            cur_op = 6'($urandom);
            while (legal(cur_op)) cur_op = 6'($urandom);
          end
        endcase
        q.push_back(PhFetch);
        q.push_back(PhDecode);
      end
      ph     = q[0];
      rdy    = ($urandom_range(0, 3) != 0);
      op_drv = (ph == PhDecode) ? cur_op : 6'($urandom);
      apply(1'b0, op_drv, rdy, model_out(ph, rdy, legal(cur_op)), "rand");
      if (!((ph == PhFetch || ph == PhRead || ph == PhWrite) && !rdy)) begin
        void'(q.pop_front());
        if (ph == PhDecode) begin
          case (cur_op)
            LW:   begin q.push_back(PhAddr); q.push_back(PhRead); q.push_back(PhLoadWb); end
            SW:   begin q.push_back(PhAddr); q.push_back(PhWrite); end
            R:    begin q.push_back(PhRExec); q.push_back(PhRWb); end
            ADDI: begin q.push_back(PhAddiExec); q.push_back(PhAddiWb); end
            BEQ:  q.push_back(PhBranch);
            J:    q.push_back(PhJump);
            default: ;
          endcase
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
